// File: rtl/fetch_sched_pkg.sv
// Purpose: shared fetch-scheduler types: FSM states, PC-mux select codes, redirect sources.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fetch_sched_pkg;

    // Fetch FSM: an access is in flight (S_WAIT) or the instruction word is valid (S_READY).
    typedef enum logic {
        S_WAIT  = 1'b0,
        S_READY = 1'b1
    } fetch_state_e;

    // PC mux select driven on pc_sel.
    typedef enum logic [1:0] {
        PC_SEL_SEQ   = 2'd0,    // PC + 4
        PC_SEL_REDIR = 2'd1     // redirect target on pc_tgt
    } pc_sel_e;

    // Which redirect request won arbitration.
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_W    = 2'd1,
        REDIR_E    = 2'd2,
        REDIR_RV   = 2'd3
    } redir_src_e;

    // The oldest instruction in the pipe wins: W beats E, and the ARM E-stage
    // branch beats the RISC-V E-stage branch/jump.
    function automatic redir_src_e redir_pick(input logic w, input logic e, input logic rv);
        redir_src_e src;
        if (w) begin
            src = REDIR_W;
        end else if (e) begin
            src = REDIR_E;
        end else if (rv) begin
            src = REDIR_RV;
        end else begin
            src = REDIR_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/fetch_sched_redir_arb.sv
// Purpose: fixed-priority arbiter across the three redirect requests; outputs valid + winning target.
// Latency: combinational, 0 cycles.
// Backpressure: none; a redirect is never held off.
// Ports: redir_w/e/rv + tgt_w/e/rv in; valid (any redirect), pc_tgt (winner's target, 0 when none) out.
module redir_arb
    import fetch_sched_pkg::*;
(
    input  logic        redir_w,
    input  logic        redir_e,
    input  logic        redir_rv,
    input  logic [31:0] tgt_w,
    input  logic [31:0] tgt_e,
    input  logic [31:0] tgt_rv,
    output logic        valid,
    output logic [31:0] pc_tgt
);

    always_comb begin
        valid  = 1'b1;
        pc_tgt = '0;
        case (redir_pick(redir_w, redir_e, redir_rv))
            REDIR_W:  pc_tgt = tgt_w;
            REDIR_E:  pc_tgt = tgt_e;
            REDIR_RV: pc_tgt = tgt_rv;
            default:  valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sched.sv
// Purpose: fetch scheduler: PC enable/select, D/E stall+flush, program-memory wait-state sequencing.
// Latency: outputs combinational; redirect -> PC load 0 cycles, PC load -> valid word WAIT_CYCLES cycles.
// Backpressure: hazard_stall holds the PC and D; redirects override stalls and flush D and E.
// Ports: clk, rst (async, active-low); redir_w/e/rv + tgt_w/e/rv; hazard_stall;
//        pc_en, pc_sel, pc_tgt, stall_d, flush_d, flush_e, fetch_busy.
// Build option: define FETCH_WAITSTATE_EN to include the wait-state FSM and counter; without it
//        WAIT_CYCLES is ignored, fetch_busy is 0 and the scheduler behaves as if always in S_READY.
module fetch_sched
    import fetch_sched_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2   // program-memory wait states per fetch, 0..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_w,
    input  logic        redir_e,
    input  logic        redir_rv,
    input  logic [31:0] tgt_w,
    input  logic [31:0] tgt_e,
    input  logic [31:0] tgt_rv,
    input  logic        hazard_stall,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc_tgt,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        fetch_busy
);

    logic redir_vld;
    logic in_wait;

    redir_arb u_redir_arb (
        .redir_w  (redir_w),
        .redir_e  (redir_e),
        .redir_rv (redir_rv),
        .tgt_w    (tgt_w),
        .tgt_e    (tgt_e),
        .tgt_rv   (tgt_rv),
        .valid    (redir_vld),
        .pc_tgt   (pc_tgt)
    );

`ifdef FETCH_WAITSTATE_EN
    localparam logic [3:0]   WAIT_LD    = 4'(WAIT_CYCLES);
    // Every PC load (and reset) starts a new access; with zero wait states
    // the word is valid straight away, so the FSM never leaves S_READY.
    localparam fetch_state_e LOAD_STATE = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;

    fetch_state_e state;
    logic [3:0]   cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_STATE;
            cnt   <= WAIT_LD;
        end else if (redir_vld) begin
            // Redirect discards whatever access was in flight.
            state <= LOAD_STATE;
            cnt   <= WAIT_LD;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    if (cnt <= 4'd1) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    // pc_en is !hazard_stall here, so that is exactly a PC load.
                    if (!hazard_stall) begin
                        state <= LOAD_STATE;
                        cnt   <= WAIT_LD;
                    end
                end
                default: begin
                    state <= LOAD_STATE;
                    cnt   <= WAIT_LD;
                end
            endcase
        end
    end

    assign in_wait = (state == S_WAIT);
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^4'(WAIT_CYCLES);
    assign in_wait         = 1'b0;
`endif

    assign fetch_busy = in_wait;

    // stall_d and flush_d are mutually exclusive in every branch: a redirect
    // forces flush and drops the stall, and in S_WAIT they are complements.
    always_comb begin
        pc_en   = 1'b0;
        pc_sel  = PC_SEL_SEQ;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (redir_vld) begin
            pc_en   = 1'b1;
            pc_sel  = PC_SEL_REDIR;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (in_wait) begin
            // No word to hand to D: insert a bubble unless D is being held.
            stall_d = hazard_stall;
            flush_d = !hazard_stall;
            flush_e = hazard_stall;
        end else begin
            pc_en   = !hazard_stall;
            stall_d = hazard_stall;
            flush_e = hazard_stall;
        end
    end

endmodule
